// File: rtl/blt_update_ctrl.sv
// Branch lookup table update sequencer: round-robin arbitration of two update sources
// into a small FIFO, drained through a registered single-write port.
module blt_update_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_key,
  input  logic [ADDR_WIDTH-1:0] req0_val,
  input  logic                  req0_hit,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_key,
  input  logic [ADDR_WIDTH-1:0] req1_val,
  input  logic                  req1_hit,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  blt_write,
  output logic [ADDR_WIDTH-1:0] blt_write_key,
  output logic [ADDR_WIDTH-1:0] blt_write_val,
  output logic                  blt_hit,
  output logic [PTR_W:0]        pending,
  output logic                  idle
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] key_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] val_mem [DEPTH];
  logic                  hit_mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  rr_pri_q, rr_pri_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] key_q, key_d;
  logic [ADDR_WIDTH-1:0] val_q, val_d;
  logic                  hit_q, hit_d;

  logic                  full, empty;
  logic                  grant0, grant1;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] push_key, push_val;
  logic                  push_hit;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // rr_pri_q == 0 favours requester 0 when both are valid.
  assign grant0 = req0_valid & (~req1_valid | ~rr_pri_q);
  assign grant1 = req1_valid & (~req0_valid |  rr_pri_q);

  assign req0_ready = grant0 & ~full & ~flush;
  assign req1_ready = grant1 & ~full & ~flush;

  assign push = req0_ready | req1_ready;
  assign pop  = ~empty & ~hold & ~flush;

  assign push_key = req1_ready ? req1_key : req0_key;
  assign push_val = req1_ready ? req1_val : req0_val;
  assign push_hit = req1_ready ? req1_hit : req0_hit;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_pri_d = rr_pri_q;
    write_d  = 1'b0;
    key_d    = key_q;
    val_d    = val_q;
    hit_d    = hit_q;

    if (req0_valid & req1_valid & push)
      rr_pri_d = ~rr_pri_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)
        wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        write_d  = 1'b1;
        key_d    = key_mem[rd_ptr_q];
        val_d    = val_mem[rd_ptr_q];
        hit_d    = hit_mem[rd_ptr_q];
      end
      if (push & ~pop)
        count_d = count_q + 1'b1;
      else if (pop & ~push)
        count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_pri_q <= 1'b0;
      write_q  <= 1'b0;
      key_q    <= '0;
      val_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_pri_q <= rr_pri_d;
      write_q  <= write_d;
      key_q    <= key_d;
      val_q    <= val_d;
      hit_q    <= hit_d;
    end
  end

  // Storage carries no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      key_mem[wr_ptr_q] <= push_key;
      val_mem[wr_ptr_q] <= push_val;
      hit_mem[wr_ptr_q] <= push_hit;
    end
  end

  assign blt_write     = write_q;
  assign blt_write_key = key_q;
  assign blt_write_val = val_q;
  assign blt_hit       = hit_q;
  assign pending       = count_q;
  assign idle          = empty & ~write_q;

endmodule

// File: tb/tb_blt_update_ctrl.sv
// Directed bench for blt_update_ctrl: latency, arbitration, full/hold, flush, async reset, wrap.
module tb_blt_update_ctrl;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req0_hit;
  logic [AW-1:0] req0_key, req0_val;
  logic          req1_valid, req1_ready, req1_hit;
  logic [AW-1:0] req1_key, req1_val;
  logic          hold, flush;
  logic          blt_write, blt_hit, idle;
  logic [AW-1:0] blt_write_key, blt_write_val;
  logic [2:0]    pending;

  int n_checks = 0;
  int n_pass   = 0;

  blt_update_ctrl #(.ADDR_WIDTH(AW), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key),
    .req0_val(req0_val), .req0_hit(req0_hit),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key),
    .req1_val(req1_val), .req1_hit(req1_hit),
    .hold(hold), .flush(flush),
    .blt_write(blt_write), .blt_write_key(blt_write_key), .blt_write_val(blt_write_val),
    .blt_hit(blt_hit), .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] k;
  int            hold_tab [6] = '{1, 1, 1, 0, 0, 1};

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_key = '0; req0_val = '0; req0_hit = 0;
    req1_valid = 0; req1_key = '0; req1_val = '0; req1_hit = 0;
    hold = 0; flush = 0;
    #12;
    check("rst_write", blt_write, 0);
    check("rst_pending", pending, 0);
    check("rst_idle", idle, 1);
    check("rst_key", blt_write_key, 0);
    @(negedge clk); reset = 1'b0;
    tick();

    // 1: single request, two-cycle latency
    req0_valid = 1; req0_key = 16'h0040; req0_val = 16'h0080; req0_hit = 1;
    #1;
    check("t1_r0_ready", req0_ready, 1);
    check("t1_r1_ready", req1_ready, 0);
    tick();
    req0_valid = 0;
    check("t1_pend1", pending, 1);
    check("t1_nowrite", blt_write, 0);
    tick();
    check("t1_write", blt_write, 1);
    check("t1_key", blt_write_key, 16'h0040);
    check("t1_val", blt_write_val, 16'h0080);
    check("t1_hit", blt_hit, 1);
    check("t1_busy", idle, 0);
    tick();
    check("t1_write_off", blt_write, 0);
    check("t1_idle", idle, 1);
    check("t1_key_held", blt_write_key, 16'h0040);

    // 2: both valid under hold, alternating grants until full
    hold = 1; req0_valid = 1; req1_valid = 1; req0_hit = 0; req1_hit = 1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      req0_key = 16'h0100 + 16'(i); req0_val = 16'h1100 + 16'(i);
      req1_key = 16'h0200 + 16'(i); req1_val = 16'h1200 + 16'(i);
      #1;
      check($sformatf("t2_r0_ready%0d", i), req0_ready, (i == 0 || i == 2) ? 1 : 0);
      check($sformatf("t2_r1_ready%0d", i), req1_ready, (i == 1 || i == 3) ? 1 : 0);
      if (i == 0 || i == 2) exp_q.push_back(16'h0100 + 16'(i));
      if (i == 1 || i == 3) exp_q.push_back(16'h0200 + 16'(i));
      tick();
      check($sformatf("t2_hold_nowrite%0d", i), blt_write, 0);
    end
    check("t2_pend_full", pending, 4);
    req0_valid = 0; req1_valid = 0; hold = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_write%0d", i), blt_write, 1);
      check($sformatf("t2_key%0d", i), blt_write_key, exp_q[i]);
    end
    tick();
    check("t2_idle", idle, 1);

    // 3: continuous req0, one write per cycle
    for (int i = 0; i < 7; i++) begin
      req0_valid = (i < 5);
      req0_key = 16'h0300 + 16'(i);
      #1;
      if (i < 5) check($sformatf("t3_ready%0d", i), req0_ready, 1);
      tick();
      check($sformatf("t3_pend%0d", i), pending, (i < 5) ? 1 : 0);
      check($sformatf("t3_write%0d", i), blt_write, (i >= 1 && i <= 5) ? 1 : 0);
      if (i >= 1 && i <= 5)
        check($sformatf("t3_key%0d", i), blt_write_key, 16'h0300 + 16'(i - 1));
    end
    req0_valid = 0;

    // 4: flush with three pending
    hold = 1; req0_valid = 1;
    for (int i = 0; i < 3; i++) begin
      req0_key = 16'h0400 + 16'(i);
      tick();
    end
    req0_valid = 0;
    check("t4_pend3", pending, 3);
    flush = 1; req1_valid = 1; req1_key = 16'h0444;
    #1;
    check("t4_r1_ready", req1_ready, 0);
    tick();
    flush = 0; req1_valid = 0; hold = 0;
    check("t4_pend0", pending, 0);
    check("t4_nowrite", blt_write, 0);
    tick();
    check("t4_nowrite2", blt_write, 0);
    check("t4_idle", idle, 1);

    // 5: async reset mid-burst; rr_pri is flipped to req1 beforehand
    req0_valid = 1; req1_valid = 1; req0_key = 16'h0500; req1_key = 16'h0600;
    #1;
    check("t5_pre_r0_ready", req0_ready, 1);
    tick();
    req1_valid = 0;
    for (int i = 1; i < 3; i++) begin
      req0_key = 16'h0500 + 16'(i);
      tick();
    end
    check("t5_pre_write", blt_write, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_write", blt_write, 0);
    check("t5_async_pend", pending, 0);
    check("t5_async_key", blt_write_key, 0);
    req0_valid = 0;
    @(negedge clk); reset = 1'b0;
    req0_valid = 1; req1_valid = 1; req0_key = 16'h0700; req1_key = 16'h0800;
    #1;
    check("t5_r0_favoured", req0_ready, 1);
    check("t5_r1_blocked", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    check("t5_write", blt_write, 1);
    check("t5_key", blt_write_key, 16'h0700);
    tick();

    // 6: six enqueues with two interleaved pops, pointers wrap
    req0_valid = 1;
    for (int i = 0; i < 6; i++) begin
      hold = hold_tab[i][0];
      req0_key = 16'h0900 + 16'(i);
      #1;
      check($sformatf("t6_ready%0d", i), req0_ready, 1);
      tick();
      check($sformatf("t6_pend%0d", i), pending, (i < 3) ? 3'(i + 1) : (i == 5 ? 3'd4 : 3'd3));
      check($sformatf("t6_write%0d", i), blt_write, (i == 3 || i == 4) ? 1 : 0);
      if (i == 3 || i == 4)
        check($sformatf("t6_key%0d", i), blt_write_key, 16'h0900 + 16'(i - 3));
    end
    req0_key = 16'h09FF;
    #1;
    check("t6_full_ready", req0_ready, 0);
    req0_valid = 0; hold = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      k = 16'h0902 + 16'(i);
      check($sformatf("t6_drain_write%0d", i), blt_write, 1);
      check($sformatf("t6_drain_key%0d", i), blt_write_key, k);
    end
    tick();
    check("t6_idle", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
